muldiv16_unit: RTL and testbench

Multi-cycle unsigned 16-bit multiply/divide unit sitting directly downstream of the 4-entry, 16-bit register file. It takes the two read ports (rd1, rd2) as operands when the control unit issues a start, iterates one bit per cycle, and returns a write-back packet (data, 2-bit destination, write strobe) that drives the register file's wd, wr and regwrite inputs. It is the only multi-cycle execution resource in the datapath; the control unit stalls on busy.

---
 rtl/muldiv16_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv16_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv16_unit.sv
// muldiv16_unit: multi-cycle unsigned 16-bit multiply/divide.
// Operands are captured on accept and processed one bit per clock. The
// write-back packet (result, wr, regwrite) feeds the register file.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | iterating, counter 0..15
// DONE  | one-cycle completion, done=1, results valid
module muldiv16_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       dest,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       wr,
    output logic             regwrite,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               op_q;
    logic [1:0]         dest_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               last_iter;
    logic               accept;
    logic               zero_div;

    assign accept    = (state == IDLE) && start;
    assign zero_div  = op && (b == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // One iteration of shift-add multiply and restoring divide.
    // The remainder stays below the divisor, so a clear top bit of the
    // 17-bit trial difference means the subtraction did not borrow.
    always_comb begin
        prod_nxt = prod;
        if (b_q[cnt]) begin
            prod_nxt = prod + ({{WIDTH{1'b0}}, a_q} << cnt);
        end
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ge};
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero divisor skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered write-back packet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            dest_q      <= '0;
            cnt         <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
            done        <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            wr          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= op;
                dest_q <= dest;
                cnt    <= '0;
                prod   <= '0;
                rem    <= '0;
                quo    <= a;
                if (zero_div) begin
                    done        <= 1'b1;
                    result      <= '1;
                    result_hi   <= a;
                    wr          <= dest;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                cnt  <= cnt + 1'b1;
                prod <= prod_nxt;
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                if (last_iter) begin
                    done        <= 1'b1;
                    result      <= op_q ? quo_nxt : prod_nxt[WIDTH-1:0];
                    result_hi   <= op_q ? rem_nxt : prod_nxt[2*WIDTH-1:WIDTH];
                    wr          <= dest_q;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign regwrite = done && (wr != 2'd0);

endmodule

// File: tb/tb_muldiv16_unit.sv
// Self-checking bench for muldiv16_unit: directed cases plus random ops
// compared against plain-arithmetic expectations.
module tb_muldiv16_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [1:0]  dest = 2'd0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [1:0]  wr;
    logic        regwrite;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;

    muldiv16_unit #(.WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .dest        (dest),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .wr          (wr),
        .regwrite    (regwrite),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Count cycles in which done is high.
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_hi"}, result_hi, 0);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_regwrite"}, regwrite, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
    endtask

    task automatic run_op(input logic o, input logic [1:0] d, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        logic [15:0] er, eh;
        logic        ez;
        int          lat, exp_lat, dc0;
        if (!o) begin
            p = {16'd0, x} * {16'd0, y};
            er = p[15:0];
            eh = p[31:16];
            ez = 1'b0;
            exp_lat = 16;
        end else if (y == 16'd0) begin
            er = 16'hFFFF;
            eh = x;
            ez = 1'b1;
            exp_lat = 0;
        end else begin
            er = x / y;
            eh = x % y;
            ez = 1'b0;
            exp_lat = 16;
        end
        @(negedge clock);
        start = 1'b1; op = o; dest = d; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0; op = ~o; dest = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
        dc0 = done_cnt;
        chk("busy_after_accept", busy, 1);
        wait_done(lat);
        chk("latency", lat, exp_lat);
        chk("result", result, er);
        chk("result_hi", result_hi, eh);
        chk("wr", wr, d);
        chk("regwrite", regwrite, (d != 2'd0));
        chk("div_by_zero", div_by_zero, ez);
        @(posedge clock);
        #1;
        chk("done_low_after", done, 0);
        chk("regwrite_low_after", regwrite, 0);
        chk("busy_low_after", busy, 0);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("result_held", result, er);
    endtask

    initial begin
        int lat, dc0;
        logic [15:0] x, y;
        logic [1:0]  d;
        logic        o;

        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk_all_zero("after_reset");

        run_op(1'b0, 2'd2, 16'd300, 16'd500);
        chk("mul300x500_lo", result, 16'h49F0);
        chk("mul300x500_hi", result_hi, 16'h0002);
        run_op(1'b0, 2'd1, 16'hFFFF, 16'hFFFF);
        chk("mulmax_lo", result, 16'h0001);
        chk("mulmax_hi", result_hi, 16'hFFFE);
        run_op(1'b1, 2'd3, 16'd1000, 16'd7);
        chk("div1000_7_q", result, 16'h008E);
        chk("div1000_7_r", result_hi, 16'h0006);
        run_op(1'b1, 2'd1, 16'd5, 16'd9);
        run_op(1'b1, 2'd2, 16'h1234, 16'd0);
        chk("dbz_flag", div_by_zero, 1);
        run_op(1'b0, 2'd2, 16'd6, 16'd7);
        chk("after_dbz_result", result, 16'd42);
        run_op(1'b0, 2'd0, 16'd3, 16'd4);
        run_op(1'b1, 2'd1, 16'hFFFF, 16'd1);
        run_op(1'b1, 2'd3, 16'd1, 16'hFFFF);

        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            d = 2'($urandom);
            x = 16'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(1, 15));
            run_op(o, d, x, y);
        end

        // Start held high with operands toggling while the unit is busy.
        @(negedge clock);
        start = 1'b1; op = 1'b0; dest = 2'd1; a = 16'd100; b = 16'd200;
        @(posedge clock);
        #1;
        dc0 = done_cnt;
        chk("held_busy", busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clock);
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            @(posedge clock);
            #1;
            lat++;
        end
        chk("held_latency", lat, 16);
        chk("held_result", result, 16'h4E20);
        chk("held_result_hi", result_hi, 16'h0000);
        @(negedge clock);
        op = 1'b1; dest = 2'd3; a = 16'd50000; b = 16'd7;
        @(posedge clock);
        #1;
        chk("held_idle_busy", busy, 0);
        chk("held_idle_done", done, 0);
        @(posedge clock);
        #1;
        chk("held_second_accept", busy, 1);
        start = 1'b0;
        wait_done(lat);
        chk("held2_latency", lat, 16);
        chk("held2_result", result, 16'(50000 / 7));
        chk("held2_result_hi", result_hi, 16'(50000 % 7));
        chk("held2_wr", wr, 3);
        @(posedge clock);
        #1;
        chk("held_done_count", done_cnt - dc0, 2);

        // Reset asserted in the middle of a multiply.
        @(negedge clock);
        start = 1'b1; op = 1'b0; dest = 2'd2; a = 16'd1234; b = 16'd5678;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("midrun_busy", busy, 1);
        dc0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk_all_zero("abort_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
